vector_dispatch_ctrl: RTL and testbench
=======================================

VECTOR_DISPATCH_CTRL -- requirements
Module: vector_dispatch_ctrl

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, instruction-queue entries (power of 2, >=2); X_ID_WIDTH, default 4, XIF id width; NUM_VREGS, default 16, vector registers (VA = $clog2(NUM_VREGS)).
REQ-002 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-003 SHALL have issue ports: issue_valid_i in 1; issue_ready_o out 1; issue_instr_i in 32; issue_id_i in X_ID_WIDTH; issue_rs1_i in 32 scalar GPR value; issue_accept_o out 1; issue_loadstore_o out 1; issue_writeback_o out 1.
REQ-004 SHALL have commit ports: commit_valid_i in 1; commit_id_i in X_ID_WIDTH; commit_kill_i in 1.
REQ-005 SHALL have LSU ports: lsu_start_o out 1; lsu_store_o out 1; lsu_addr_o out 32; lsu_vreg_o out VA; lsu_done_i in 1.
REQ-006 SHALL have EXEC ports: exec_start_o out 1; exec_funct7_o out 7; exec_funct3_o out 3; exec_vs1_o out VA; exec_vs2_o out VA; exec_done_i in 1.
REQ-007 SHALL have VRF write ports: vrf_we_o out 1; vrf_waddr_o out VA; vrf_wsel_o out 1 (1 = LSU load data, 0 = EXEC result).
REQ-008 SHALL have result/status ports: result_valid_o out 1; result_ready_i in 1; result_id_o out X_ID_WIDTH; busy_o out 1; count_o out $clog2(DEPTH+1).

Function
REQ-009 SHALL decode combinationally: opcode 7'b0001011 with funct7 in {VLD 0000001, VST 0000010, VADD 0000011, VSUB 0000100, VMUL 0000101, VMATMUL 0001000} is legal; the instruction is a load if funct7 is VLD and a store if funct7 is VST.
REQ-010 SHALL drive issue_ready_o = (count_o < DEPTH); issue_accept_o = issue_valid_i & ready & legal; issue_loadstore_o = accept & (VLD|VST); issue_writeback_o = 1'b0 always (no GPR writes).
REQ-011 SHALL, on accept, enqueue at tail: id, funct7, funct3, rd, rs1 field, rs2 field, scalar rs1 value, committed=0, killed=0; an illegal instruction is not enqueued.
REQ-012 SHALL, on commit_valid_i, set committed=1 (and killed=commit_kill_i) on every valid entry whose id matches, including an entry being enqueued in the same cycle; a commit with no matching id is ignored.
REQ-013 SHALL run a dispatch FSM: IDLE, DISPATCH, WAIT, WR_VRF, RESULT; reset state IDLE.
REQ-014 IDLE: head valid & committed & killed -> pop head, no result, stay IDLE; head valid & committed & !killed -> DISPATCH; otherwise stay IDLE.
REQ-015 DISPATCH: single-cycle lsu_start_o (VLD/VST, lsu_store_o = VST, lsu_addr_o = scalar, lsu_vreg_o = rd) or exec_start_o (funct7, funct3, vs1 = rs1 field, vs2 = rs2 field) -> WAIT.
REQ-016 WAIT: on the relevant done_i -> WR_VRF for VLD/arith, RESULT for VST; done of the non-selected unit is ignored.
REQ-017 WR_VRF: single-cycle vrf_we_o, vrf_waddr_o = rd[VA-1:0], vrf_wsel_o = (funct7 == VLD) -> RESULT.
REQ-018 RESULT: result_valid_o = 1, result_id_o = head id, held stable until result_ready_i; in the handshake cycle pop head -> IDLE.
REQ-019 SHALL allow enqueue and pop in the same cycle; count_o unchanged then; pointers wrap modulo DEPTH.
REQ-020 SHALL keep start/we/valid strobes 0 outside their states; busy_o = (state != IDLE) | (count_o != 0).
REQ-021 SHALL dispatch strictly in program order, one instruction in flight; minimum latency from commit of the head to result_valid_o is 4 cycles for VLD/arith (3 for VST) with done_i returned the cycle after start.

Reset
REQ-022 SHALL, on rst_ni low, at any time including mid-operation, clear the queue, pointers, count_o and FSM (IDLE), and drive every output 0 except issue_ready_o = 1 after reset.
REQ-023 SHALL ignore done_i pulses arriving after reset for instructions dispatched before it.

Structure
REQ-024 SHALL place the opcode/funct7 constants, the queue-entry struct and the FSM state enum in shared package vec_pkg.
REQ-025 SHALL implement decode (REQ-009) as sub-module vec_instr_decoder; queue and FSM reside in the top.

Verification
REQ-026 VADD id=3, commit id=3 kill=0, exec_done 1 cycle after start -> exec_start_o with funct7=0000011; vrf_we_o with vrf_wsel_o=0; result_id_o=3.
REQ-027 VLD rs1_val=0x1000 rd=5, commit -> lsu_start_o, lsu_addr_o=0x1000, lsu_store_o=0; vrf_we_o, waddr=5, wsel=1; one result.
REQ-028 Issue ids 1..4 (DEPTH=4), no commits -> issue_ready_o=0, count_o=4; a 5th issue is not accepted; commit id 1 -> ready returns after id 1 result handshake.
REQ-029 Issue ids 2,3; commit 2 kill=1, commit 3 kill=0 -> no start for id 2; only id 3 dispatched; result_id_o=3 only.
REQ-030 Funct7=1111111 -> issue_accept_o=0, count_o unchanged; result_ready_i held 0 in RESULT -> result_valid_o/result_id_o stable for 10 cycles; rst_ni low in WAIT -> FSM IDLE, count_o=0.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants, queue-entry layout and dispatch FSM states for the
// vector dispatch controller.
package vec_pkg;

   localparam logic [6:0] OPC_VEC     = 7'b0001011;
   localparam logic [6:0] F7_VLD      = 7'b0000001;
   localparam logic [6:0] F7_VST      = 7'b0000010;
   localparam logic [6:0] F7_VADD     = 7'b0000011;
   localparam logic [6:0] F7_VSUB     = 7'b0000100;
   localparam logic [6:0] F7_VMUL     = 7'b0000101;
   localparam logic [6:0] F7_VMATMUL  = 7'b0001000;

   // Ids are stored at a fixed maximal width so the struct is parameter-free;
   // X_ID_WIDTH of the controller must not exceed this.
   localparam int ID_MAX_W = 16;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [6:0]          funct7;
      logic [2:0]          funct3;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [31:0]         rs1_val;
      logic                committed;
      logic                killed;
   } queue_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DISPATCH,
      ST_WAIT,
      ST_WR_VRF,
      ST_RESULT
   } disp_state_e;

   function automatic logic is_legal_funct7(input logic [6:0] funct7);
      return funct7 inside {F7_VLD, F7_VST, F7_VADD, F7_VSUB, F7_VMUL, F7_VMATMUL};
   endfunction

   function automatic logic is_mem_funct7(input logic [6:0] funct7);
      return (funct7 == F7_VLD) || (funct7 == F7_VST);
   endfunction

endpackage

// File: rtl/vec_instr_decoder.sv
// Combinational decode of a custom-0 vector instruction: legality,
// load/store class and the raw register/function fields.
module vec_instr_decoder
   import vec_pkg::*;
(
   input  logic [31:0] instr,
   output logic        legal,
   output logic        is_load,
   output logic        is_store,
   output logic [6:0]  funct7,
   output logic [2:0]  funct3,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2
);

   assign funct7   = instr[31:25];
   assign rs2      = instr[24:20];
   assign rs1      = instr[19:15];
   assign funct3   = instr[14:12];
   assign rd       = instr[11:7];

   assign legal    = (instr[6:0] == OPC_VEC) && is_legal_funct7(funct7);
   assign is_load  = legal && (funct7 == F7_VLD);
   assign is_store = legal && (funct7 == F7_VST);

endmodule

// File: rtl/vector_dispatch_ctrl.sv
// Vector coprocessor dispatch controller: in-order instruction queue fed by
// the XIF issue/commit interface, with a single-in-flight dispatch FSM.
module vector_dispatch_ctrl
   import vec_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int X_ID_WIDTH = 4,
   parameter int NUM_VREGS  = 16,
   localparam int VA        = $clog2(NUM_VREGS),
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,

   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [31:0]           issue_instr_i,
   input  logic [X_ID_WIDTH-1:0] issue_id_i,
   input  logic [31:0]           issue_rs1_i,
   output logic                  issue_accept_o,
   output logic                  issue_loadstore_o,
   output logic                  issue_writeback_o,

   input  logic                  commit_valid_i,
   input  logic [X_ID_WIDTH-1:0] commit_id_i,
   input  logic                  commit_kill_i,

   output logic                  lsu_start_o,
   output logic                  lsu_store_o,
   output logic [31:0]           lsu_addr_o,
   output logic [VA-1:0]         lsu_vreg_o,
   input  logic                  lsu_done_i,

   output logic                  exec_start_o,
   output logic [6:0]            exec_funct7_o,
   output logic [2:0]            exec_funct3_o,
   output logic [VA-1:0]         exec_vs1_o,
   output logic [VA-1:0]         exec_vs2_o,
   input  logic                  exec_done_i,

   output logic                  vrf_we_o,
   output logic [VA-1:0]         vrf_waddr_o,
   output logic                  vrf_wsel_o,

   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [X_ID_WIDTH-1:0] result_id_o,
   output logic                  busy_o,
   output logic [CW-1:0]         count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   queue_entry_t        entries_q [DEPTH];
   logic [DEPTH-1:0]    valid_q;
   logic [PW-1:0]       head_q;
   logic [PW-1:0]       tail_q;
   logic [CW-1:0]       count_q;
   disp_state_e         state_q;
   disp_state_e         state_d;

   logic                dec_legal;
   logic                dec_is_load;
   logic                dec_is_store;
   logic [6:0]          dec_funct7;
   logic [2:0]          dec_funct3;
   logic [4:0]          dec_rd;
   logic [4:0]          dec_rs1;
   logic [4:0]          dec_rs2;

   logic                ready;
   logic                accept;
   logic                pop;
   logic                head_valid;
   logic                head_is_mem;
   logic                head_is_store;
   logic                new_commit_hit;
   logic [ID_MAX_W-1:0] issue_id_ext;
   logic [ID_MAX_W-1:0] commit_id_ext;
   queue_entry_t        head;
   queue_entry_t        new_entry;
   logic                unused_head_bits;

   vec_instr_decoder u_decoder (
      .instr    (issue_instr_i),
      .legal    (dec_legal),
      .is_load  (dec_is_load),
      .is_store (dec_is_store),
      .funct7   (dec_funct7),
      .funct3   (dec_funct3),
      .rd       (dec_rd),
      .rs1      (dec_rs1),
      .rs2      (dec_rs2)
   );

   assign issue_id_ext      = ID_MAX_W'(issue_id_i);
   assign commit_id_ext     = ID_MAX_W'(commit_id_i);

   assign ready             = (count_q < CW'(DEPTH));
   assign accept            = issue_valid_i & ready & dec_legal;
   assign issue_ready_o     = ready;
   assign issue_accept_o    = accept;
   assign issue_loadstore_o = accept & (dec_is_load | dec_is_store);
   assign issue_writeback_o = 1'b0;

   assign head              = entries_q[head_q];
   assign head_valid        = valid_q[head_q];
   assign head_is_mem       = is_mem_funct7(head.funct7);
   assign head_is_store     = (head.funct7 == F7_VST);
   assign unused_head_bits  = ^{head.rd, head.rs1, head.rs2};

   assign count_o           = count_q;
   assign busy_o            = (state_q != ST_IDLE) | (count_q != '0);

   // A commit that names the instruction being issued this very cycle must
   // land on the new entry, otherwise it would be lost.
   assign new_commit_hit    = commit_valid_i && (commit_id_ext == issue_id_ext);

   always_comb begin
      new_entry           = '0;
      new_entry.id        = issue_id_ext;
      new_entry.funct7    = dec_funct7;
      new_entry.funct3    = dec_funct3;
      new_entry.rd        = dec_rd;
      new_entry.rs1       = dec_rs1;
      new_entry.rs2       = dec_rs2;
      new_entry.rs1_val   = issue_rs1_i;
      new_entry.committed = new_commit_hit;
      new_entry.killed    = new_commit_hit & commit_kill_i;
   end

   // Queue storage: commit marking, pop at head, push at tail. Push and pop
   // never touch the same slot because push needs room and pop needs an entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid_i && valid_q[i] && (entries_q[i].id == commit_id_ext)) begin
               entries_q[i].committed <= 1'b1;
               entries_q[i].killed    <= commit_kill_i;
            end
         end
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PW'(1);
         end
         if (accept) begin
            entries_q[tail_q] <= new_entry;
            valid_q[tail_q]   <= 1'b1;
            tail_q            <= tail_q + PW'(1);
         end
         case ({accept, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (head_valid && head.committed && !head.killed) begin
               state_d = ST_DISPATCH;
            end
         end
         ST_DISPATCH: state_d = ST_WAIT;
         ST_WAIT: begin
            if (head_is_mem ? lsu_done_i : exec_done_i) begin
               state_d = head_is_store ? ST_RESULT : ST_WR_VRF;
            end
         end
         ST_WR_VRF: state_d = ST_RESULT;
         ST_RESULT: begin
            if (result_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Data outputs are gated by their strobes so nothing stale leaks out.
   always_comb begin
      lsu_start_o    = 1'b0;
      lsu_store_o    = 1'b0;
      lsu_addr_o     = '0;
      lsu_vreg_o     = '0;
      exec_start_o   = 1'b0;
      exec_funct7_o  = '0;
      exec_funct3_o  = '0;
      exec_vs1_o     = '0;
      exec_vs2_o     = '0;
      vrf_we_o       = 1'b0;
      vrf_waddr_o    = '0;
      vrf_wsel_o     = 1'b0;
      result_valid_o = 1'b0;
      result_id_o    = '0;
      pop            = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pop = head_valid & head.committed & head.killed;
         end
         ST_DISPATCH: begin
            if (head_is_mem) begin
               lsu_start_o = 1'b1;
               lsu_store_o = head_is_store;
               lsu_addr_o  = head.rs1_val;
               lsu_vreg_o  = head.rd[VA-1:0];
            end else begin
               exec_start_o  = 1'b1;
               exec_funct7_o = head.funct7;
               exec_funct3_o = head.funct3;
               exec_vs1_o    = head.rs1[VA-1:0];
               exec_vs2_o    = head.rs2[VA-1:0];
            end
         end
         ST_WR_VRF: begin
            vrf_we_o    = 1'b1;
            vrf_waddr_o = head.rd[VA-1:0];
            vrf_wsel_o  = (head.funct7 == F7_VLD);
         end
         ST_RESULT: begin
            result_valid_o = 1'b1;
            result_id_o    = head.id[X_ID_WIDTH-1:0];
            pop            = result_ready_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vector_dispatch_ctrl.sv
// Self-checking bench for vector_dispatch_ctrl: directed scenarios plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_vector_dispatch_ctrl;

   localparam int DEPTH      = 4;
   localparam int X_ID_WIDTH = 4;
   localparam int NUM_VREGS  = 16;
   localparam int VA         = $clog2(NUM_VREGS);
   localparam int CW         = $clog2(DEPTH + 1);

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic                  issue_valid_i;
   logic                  issue_ready_o;
   logic [31:0]           issue_instr_i;
   logic [X_ID_WIDTH-1:0] issue_id_i;
   logic [31:0]           issue_rs1_i;
   logic                  issue_accept_o;
   logic                  issue_loadstore_o;
   logic                  issue_writeback_o;
   logic                  commit_valid_i;
   logic [X_ID_WIDTH-1:0] commit_id_i;
   logic                  commit_kill_i;
   logic                  lsu_start_o;
   logic                  lsu_store_o;
   logic [31:0]           lsu_addr_o;
   logic [VA-1:0]         lsu_vreg_o;
   logic                  lsu_done_i;
   logic                  exec_start_o;
   logic [6:0]            exec_funct7_o;
   logic [2:0]            exec_funct3_o;
   logic [VA-1:0]         exec_vs1_o;
   logic [VA-1:0]         exec_vs2_o;
   logic                  exec_done_i;
   logic                  vrf_we_o;
   logic [VA-1:0]         vrf_waddr_o;
   logic                  vrf_wsel_o;
   logic                  result_valid_o;
   logic                  result_ready_i;
   logic [X_ID_WIDTH-1:0] result_id_o;
   logic                  busy_o;
   logic [CW-1:0]         count_o;

   vector_dispatch_ctrl #(
      .DEPTH      (DEPTH),
      .X_ID_WIDTH (X_ID_WIDTH),
      .NUM_VREGS  (NUM_VREGS)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .issue_valid_i     (issue_valid_i),
      .issue_ready_o     (issue_ready_o),
      .issue_instr_i     (issue_instr_i),
      .issue_id_i        (issue_id_i),
      .issue_rs1_i       (issue_rs1_i),
      .issue_accept_o    (issue_accept_o),
      .issue_loadstore_o (issue_loadstore_o),
      .issue_writeback_o (issue_writeback_o),
      .commit_valid_i    (commit_valid_i),
      .commit_id_i       (commit_id_i),
      .commit_kill_i     (commit_kill_i),
      .lsu_start_o       (lsu_start_o),
      .lsu_store_o       (lsu_store_o),
      .lsu_addr_o        (lsu_addr_o),
      .lsu_vreg_o        (lsu_vreg_o),
      .lsu_done_i        (lsu_done_i),
      .exec_start_o      (exec_start_o),
      .exec_funct7_o     (exec_funct7_o),
      .exec_funct3_o     (exec_funct3_o),
      .exec_vs1_o        (exec_vs1_o),
      .exec_vs2_o        (exec_vs2_o),
      .exec_done_i       (exec_done_i),
      .vrf_we_o          (vrf_we_o),
      .vrf_waddr_o       (vrf_waddr_o),
      .vrf_wsel_o        (vrf_wsel_o),
      .result_valid_o    (result_valid_o),
      .result_ready_i    (result_ready_i),
      .result_id_o       (result_id_o),
      .busy_o            (busy_o),
      .count_o           (count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          id;
      int          f7;
      int          f3;
      int          rd;
      int          rs1f;
      int          rs2f;
      int unsigned rs1v;
      bit          committed;
      bit          killed;
   } mEntry;

   // Reference model: program-ordered queue plus the step of the one
   // instruction in flight (0 free, 1 start, 2 awaiting done, 3 VRF write, 4 result).
   mEntry mq[$];
   int    phase      = 0;
   int    checks     = 0;
   int    failures   = 0;
   int    startCount = 0;
   int    legalF7[6] = '{1, 2, 3, 4, 5, 8};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mkInstr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
      return {f7, rs2, rs1, f3, rd, 7'b0001011};
   endfunction

   function automatic bit benchLegal(input logic [31:0] instr);
      int f7;
      f7 = int'(instr[31:25]);
      return (instr[6:0] == 7'b0001011) &&
             (f7 == 1 || f7 == 2 || f7 == 3 || f7 == 4 || f7 == 5 || f7 == 8);
   endfunction

   task automatic modelStep();
      int    cnt;
      bit    hv;
      mEntry h;
      mEntry e;
      bit    hMem;
      bit    hSt;
      bit    expAccept;
      bit    lsuS;
      bit    exeS;
      bit    we;
      bit    rv;
      bit    doPop;
      int    np;
      int    f7;
      cnt  = mq.size();
      hv   = (cnt != 0);
      h    = '{default: 0};
      if (hv) h = mq[0];
      hMem = (h.f7 == 1) || (h.f7 == 2);
      hSt  = (h.f7 == 2);
      f7   = int'(issue_instr_i[31:25]);
      expAccept = issue_valid_i && (cnt < DEPTH) && benchLegal(issue_instr_i);
      lsuS = (phase == 1) && hMem;
      exeS = (phase == 1) && !hMem;
      we   = (phase == 3);
      rv   = (phase == 4);

      checkOutput("issue_ready", issue_ready_o, cnt < DEPTH);
      checkOutput("issue_accept", issue_accept_o, expAccept);
      checkOutput("issue_loadstore", issue_loadstore_o, expAccept && (f7 == 1 || f7 == 2));
      checkOutput("issue_writeback", issue_writeback_o, 0);
      checkOutput("count", count_o, cnt);
      checkOutput("busy", busy_o, (phase != 0) || (cnt != 0));
      checkOutput("lsu_start", lsu_start_o, lsuS);
      checkOutput("lsu_store", lsu_store_o, lsuS && hSt);
      checkOutput("lsu_addr", lsu_addr_o, lsuS ? h.rs1v : 0);
      checkOutput("lsu_vreg", lsu_vreg_o, lsuS ? h.rd % NUM_VREGS : 0);
      checkOutput("exec_start", exec_start_o, exeS);
      checkOutput("exec_funct7", exec_funct7_o, exeS ? h.f7 : 0);
      checkOutput("exec_funct3", exec_funct3_o, exeS ? h.f3 : 0);
      checkOutput("exec_vs1", exec_vs1_o, exeS ? h.rs1f % NUM_VREGS : 0);
      checkOutput("exec_vs2", exec_vs2_o, exeS ? h.rs2f % NUM_VREGS : 0);
      checkOutput("vrf_we", vrf_we_o, we);
      checkOutput("vrf_waddr", vrf_waddr_o, we ? h.rd % NUM_VREGS : 0);
      checkOutput("vrf_wsel", vrf_wsel_o, we && (h.f7 == 1));
      checkOutput("result_valid", result_valid_o, rv);
      checkOutput("result_id", result_id_o, rv ? h.id : 0);

      doPop = 0;
      np    = phase;
      case (phase)
         0: if (hv && h.committed) begin
               if (h.killed) doPop = 1;
               else          np = 1;
            end
         1: np = 2;
         2: if (hMem ? lsu_done_i : exec_done_i) np = hSt ? 4 : 3;
         3: np = 4;
         4: if (result_ready_i) begin
               np    = 0;
               doPop = 1;
            end
         default: np = 0;
      endcase
      if (commit_valid_i) begin
         foreach (mq[i]) begin
            if (mq[i].id == int'(commit_id_i)) begin
               mq[i].committed = 1;
               mq[i].killed    = commit_kill_i;
            end
         end
      end
      if (doPop) void'(mq.pop_front());
      if (expAccept) begin
         e.id        = int'(issue_id_i);
         e.f7        = f7;
         e.f3        = int'(issue_instr_i[14:12]);
         e.rd        = int'(issue_instr_i[11:7]);
         e.rs1f      = int'(issue_instr_i[19:15]);
         e.rs2f      = int'(issue_instr_i[24:20]);
         e.rs1v      = issue_rs1_i;
         e.committed = commit_valid_i && (commit_id_i == issue_id_i);
         e.killed    = e.committed && commit_kill_i;
         mq.push_back(e);
      end
      phase = np;
   endtask

   always @(negedge clk_i) begin : compare_proc
      if (!rst_ni) begin
         checkOutput("rst_issue_ready", issue_ready_o, 1);
         checkOutput("rst_count", count_o, 0);
         checkOutput("rst_busy", busy_o, 0);
         checkOutput("rst_strobes", {lsu_start_o, exec_start_o, vrf_we_o, result_valid_o, issue_accept_o}, 0);
         checkOutput("rst_result_id", result_id_o, 0);
         mq.delete();
         phase = 0;
      end else begin
         if (lsu_start_o || exec_start_o) startCount++;
         modelStep();
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input bit iv, input logic [31:0] instr, input int id,
                                input logic [31:0] rs1v, input bit cv, input int cid,
                                input bit kill);
      issue_valid_i  = iv;
      issue_instr_i  = instr;
      issue_id_i     = X_ID_WIDTH'(id);
      issue_rs1_i    = rs1v;
      commit_valid_i = cv;
      commit_id_i    = X_ID_WIDTH'(cid);
      commit_kill_i  = kill;
      #1;
   endtask

   task automatic idleInputs();
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 0);
   endtask

   task automatic waitResult(input int maxCycles);
      int n;
      n = 0;
      while (!result_valid_o && n < maxCycles) begin
         tick();
         n++;
      end
      if (!result_valid_o) checkOutput("result_timeout", 0, 1);
   endtask

   initial begin
      rst_ni         = 1'b0;
      lsu_done_i     = 1'b0;
      exec_done_i    = 1'b0;
      result_ready_i = 1'b0;
      idleInputs();
      tick();
      tick();
      checkOutput("reset_ready", issue_ready_o, 1);
      checkOutput("reset_count", count_o, 0);
      checkOutput("reset_result_valid", result_valid_o, 0);
      rst_ni = 1'b1;
      tick();

      // VADD id=3 committed in its issue cycle, exec done one cycle after start
      applyStimulus(1, mkInstr(7'b0000011, 3'd2, 5'd7, 5'd1, 5'd2), 3, 32'h0, 1, 3, 0);
      checkOutput("vadd_accept", issue_accept_o, 1);
      checkOutput("vadd_loadstore", issue_loadstore_o, 0);
      tick();
      idleInputs();
      checkOutput("vadd_count", count_o, 1);
      checkOutput("vadd_no_early_start", exec_start_o, 0);
      tick();
      checkOutput("vadd_exec_start", exec_start_o, 1);
      checkOutput("vadd_funct7", exec_funct7_o, 7'b0000011);
      checkOutput("vadd_vs1", exec_vs1_o, 1);
      checkOutput("vadd_vs2", exec_vs2_o, 2);
      checkOutput("vadd_no_lsu", lsu_start_o, 0);
      tick();
      exec_done_i = 1'b1;
      checkOutput("vadd_start_single", exec_start_o, 0);
      tick();
      exec_done_i = 1'b0;
      checkOutput("vadd_vrf_we", vrf_we_o, 1);
      checkOutput("vadd_wsel", vrf_wsel_o, 0);
      checkOutput("vadd_waddr", vrf_waddr_o, 7);
      tick();
      checkOutput("vadd_result_valid", result_valid_o, 1);
      checkOutput("vadd_result_id", result_id_o, 3);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      checkOutput("vadd_done_valid", result_valid_o, 0);
      checkOutput("vadd_done_count", count_o, 0);

      // VLD rs1=0x1000 rd=5
      applyStimulus(1, mkInstr(7'b0000001, 3'd0, 5'd5, 5'd3, 5'd0), 6, 32'h1000, 1, 6, 0);
      checkOutput("vld_loadstore", issue_loadstore_o, 1);
      tick();
      idleInputs();
      tick();
      checkOutput("vld_lsu_start", lsu_start_o, 1);
      checkOutput("vld_addr", lsu_addr_o, 32'h1000);
      checkOutput("vld_store", lsu_store_o, 0);
      checkOutput("vld_vreg", lsu_vreg_o, 5);
      tick();
      lsu_done_i = 1'b1;
      tick();
      lsu_done_i = 1'b0;
      checkOutput("vld_vrf_we", vrf_we_o, 1);
      checkOutput("vld_waddr", vrf_waddr_o, 5);
      checkOutput("vld_wsel", vrf_wsel_o, 1);
      tick();
      checkOutput("vld_result", result_valid_o, 1);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      checkOutput("vld_one_result", result_valid_o, 0);

      // Fill the queue with ids 1..4 and no commits
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1, mkInstr(7'b0000100, 3'd0, 5'(i), 5'd0, 5'd0), i, 32'h0, 0, 0, 0);
         tick();
      end
      idleInputs();
      checkOutput("full_ready", issue_ready_o, 0);
      checkOutput("full_count", count_o, 4);
      applyStimulus(1, mkInstr(7'b0000011, 3'd0, 5'd9, 5'd0, 5'd0), 5, 32'h0, 0, 0, 0);
      checkOutput("full_fifth_accept", issue_accept_o, 0);
      tick();
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, 0);
      checkOutput("full_count_hold", count_o, 4);
      tick();
      idleInputs();
      exec_done_i = 1'b1;
      waitResult(20);
      exec_done_i = 1'b0;
      checkOutput("full_result_id", result_id_o, 1);
      checkOutput("full_ready_before_hs", issue_ready_o, 0);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      checkOutput("full_ready_after_hs", issue_ready_o, 1);
      checkOutput("full_count_after_hs", count_o, 3);
      for (int i = 2; i <= 4; i++) begin
         applyStimulus(0, 32'h0, 0, 32'h0, 1, i, 1);
         tick();
      end
      idleInputs();
      tick();
      tick();
      checkOutput("killed_drain_count", count_o, 0);

      // Kill id 2, keep id 3
      startCount = 0;
      applyStimulus(1, mkInstr(7'b0000101, 3'd1, 5'd2, 5'd0, 5'd0), 2, 32'h0, 0, 0, 0);
      tick();
      applyStimulus(1, mkInstr(7'b0000100, 3'd1, 5'd3, 5'd0, 5'd0), 3, 32'h0, 0, 0, 0);
      tick();
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 2, 1);
      tick();
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 3, 0);
      tick();
      idleInputs();
      exec_done_i = 1'b1;
      lsu_done_i  = 1'b1;
      waitResult(20);
      exec_done_i = 1'b0;
      lsu_done_i  = 1'b0;
      checkOutput("kill_result_id", result_id_o, 3);
      checkOutput("kill_start_count", startCount, 1);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      tick();
      checkOutput("kill_idle_busy", busy_o, 0);

      // Illegal funct7 and illegal opcode are rejected
      applyStimulus(1, mkInstr(7'b1111111, 3'd0, 5'd1, 5'd1, 5'd1), 5, 32'h0, 0, 0, 0);
      checkOutput("illegal_f7_accept", issue_accept_o, 0);
      tick();
      applyStimulus(1, 32'h0200_0033, 5, 32'h0, 0, 0, 0);
      checkOutput("illegal_opc_accept", issue_accept_o, 0);
      tick();
      idleInputs();
      checkOutput("illegal_count", count_o, 0);

      // VST result held while result_ready stays low
      applyStimulus(1, mkInstr(7'b0000010, 3'd0, 5'd4, 5'd0, 5'd0), 9, 32'h2000, 1, 9, 0);
      tick();
      idleInputs();
      lsu_done_i = 1'b1;
      waitResult(20);
      lsu_done_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checkOutput("hold_valid", result_valid_o, 1);
         checkOutput("hold_id", result_id_o, 9);
         tick();
      end
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;

      // Reset while waiting for done, then a stale done
      applyStimulus(1, mkInstr(7'b0000011, 3'd0, 5'd6, 5'd0, 5'd0), 4, 32'h0, 1, 4, 0);
      tick();
      idleInputs();
      tick();
      tick();
      checkOutput("wait_busy", busy_o, 1);
      rst_ni = 1'b0;
      #1;
      checkOutput("midrst_count", count_o, 0);
      checkOutput("midrst_busy", busy_o, 0);
      checkOutput("midrst_ready", issue_ready_o, 1);
      tick();
      exec_done_i = 1'b1;
      rst_ni      = 1'b1;
      tick();
      exec_done_i = 1'b0;
      checkOutput("stale_done_we", vrf_we_o, 0);
      checkOutput("stale_done_busy", busy_o, 0);

      // Randomized traffic, checked by the compare process
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [31:0] instr;
         int          cid;
         if (cyc == 1500) begin
            idleInputs();
            lsu_done_i     = 1'b0;
            exec_done_i    = 1'b0;
            result_ready_i = 1'b0;
            rst_ni         = 1'b0;
            tick();
            tick();
            rst_ni = 1'b1;
         end
         if ($urandom_range(0, 19) < 17) begin
            instr = mkInstr(7'(legalF7[$urandom_range(0, 5)]), 3'($urandom), 5'($urandom),
                            5'($urandom), 5'($urandom));
         end else begin
            instr = $urandom;
         end
         if (mq.size() > 0 && $urandom_range(0, 9) < 8) cid = mq[$urandom_range(0, mq.size() - 1)].id;
         else cid = int'($urandom_range(0, 15));
         lsu_done_i     = 1'($urandom_range(0, 1));
         exec_done_i    = 1'($urandom_range(0, 1));
         result_ready_i = 1'($urandom_range(0, 1));
         applyStimulus(1'($urandom_range(0, 1)), instr, int'($urandom_range(0, 15)), $urandom,
                       ($urandom_range(0, 9) < 4), cid, ($urandom_range(0, 3) == 0));
         tick();
      end
      idleInputs();
      lsu_done_i     = 1'b0;
      exec_done_i    = 1'b0;
      result_ready_i = 1'b0;
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
